// File: rtl/ioctl_download_tx.sv
// Host-side MiSTer ioctl download source: turns a valid/ready byte stream into
// ioctl_wr strobes framed by a PRE/POST download window, honouring ioctl_wait.
module ioctl_download_tx #(
   parameter int PRE_CYCLES  = 16,
   parameter int POST_CYCLES = 16,
   parameter int WR_GAP      = 3
) (
   input  logic        clk_sys,
   input  logic        reset,
   input  logic        start,
   input  logic [7:0]  index,
   input  logic [24:0] length,
   input  logic        src_valid,
   input  logic [7:0]  src_data,
   output logic        src_ready,
   input  logic        ioctl_wait,
   output logic        ioctl_download,
   output logic        ioctl_wr,
   output logic [24:0] ioctl_addr,
   output logic [7:0]  ioctl_dout,
   output logic [7:0]  ioctl_index,
   output logic        busy,
   output logic        done
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_PRE,
      S_FETCH,
      S_WRITE,
      S_GAP,
      S_POST
   } state_t;

   localparam logic [15:0] PRE_LAST  = 16'(PRE_CYCLES - 1);
   localparam logic [15:0] POST_LAST = 16'(POST_CYCLES - 1);
   localparam logic [15:0] GAP_LAST  = 16'(WR_GAP - 1);

   state_t      state, state_n;
   logic [15:0] cnt;
   logic        cnt_clr;
   logic [24:0] remaining;
   logic        gap_last;
   logic        fetch_hs;

   // The gap counter saturates so a long ioctl_wait stall keeps gap_last true.
   assign gap_last       = (cnt >= GAP_LAST);
   assign fetch_hs       = (state == S_FETCH) && src_valid && !ioctl_wait;
   assign busy           = (state != S_IDLE);
   assign ioctl_download = busy;

   always_comb begin
      state_n   = state;
      cnt_clr   = 1'b0;
      src_ready = 1'b0;
      ioctl_wr  = 1'b0;
      done      = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) begin
               state_n = S_PRE;
               cnt_clr = 1'b1;
            end
         end
         S_PRE: begin
            if (cnt == PRE_LAST) begin
               cnt_clr = 1'b1;
               state_n = (remaining != 25'd0) ? S_FETCH : S_POST;
            end
         end
         S_FETCH: begin
            src_ready = !ioctl_wait;
            if (src_valid && !ioctl_wait) state_n = S_WRITE;
         end
         S_WRITE: begin
            ioctl_wr = 1'b1;
            cnt_clr  = 1'b1;
            state_n  = S_GAP;
         end
         S_GAP: begin
            if (gap_last && !ioctl_wait) begin
               cnt_clr = 1'b1;
               state_n = (remaining != 25'd0) ? S_FETCH : S_POST;
            end
         end
         S_POST: begin
            if (cnt == POST_LAST) begin
               cnt_clr = 1'b1;
               done    = 1'b1;
               state_n = S_IDLE;
            end
         end
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         state <= S_IDLE;
         cnt   <= 16'd0;
      end else begin
         state <= state_n;
         if (cnt_clr)
            cnt <= 16'd0;
         else if (busy && cnt != 16'hFFFF)
            cnt <= cnt + 16'd1;
      end
   end

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         remaining   <= 25'd0;
         ioctl_addr  <= 25'd0;
         ioctl_dout  <= 8'd0;
         ioctl_index <= 8'd0;
      end else begin
         if (state == S_IDLE && start) begin
            ioctl_index <= index;
            remaining   <= length;
            ioctl_addr  <= 25'd0;
         end
         if (fetch_hs)
            ioctl_dout <= src_data;
         if (state == S_WRITE)
            remaining <= remaining - 25'd1;
         // Address advances only when another byte follows, so it ends at length-1.
         if (state == S_GAP && gap_last && !ioctl_wait && remaining != 25'd0)
            ioctl_addr <= ioctl_addr + 25'd1;
      end
   end

endmodule

// File: tb/tb_ioctl_download_tx.sv
// Bench for ioctl_download_tx: table of transfers checked through a write
// scoreboard, plus hand sequences for wait stalls, ignored start and reset.
module tb_ioctl_download_tx;

   localparam int PRE  = 16;
   localparam int POST = 16;
   localparam int GAP  = 3;

   logic        clk_sys = 1'b0;
   logic        reset;
   logic        start;
   logic [7:0]  index;
   logic [24:0] length;
   logic        src_valid;
   logic [7:0]  src_data;
   logic        src_ready;
   logic        ioctl_wait;
   logic        ioctl_download;
   logic        ioctl_wr;
   logic [24:0] ioctl_addr;
   logic [7:0]  ioctl_dout;
   logic [7:0]  ioctl_index;
   logic        busy;
   logic        done;

   ioctl_download_tx #(.PRE_CYCLES(PRE), .POST_CYCLES(POST), .WR_GAP(GAP)) dut (
      .clk_sys(clk_sys), .reset(reset), .start(start), .index(index),
      .length(length), .src_valid(src_valid), .src_data(src_data),
      .src_ready(src_ready), .ioctl_wait(ioctl_wait),
      .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
      .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
      .ioctl_index(ioctl_index), .busy(busy), .done(done)
   );

   always #5 clk_sys = ~clk_sys;

   typedef struct {
      logic [24:0] addr;
      logic [7:0]  data;
   } exp_t;

   typedef struct {
      int         len;
      logic [7:0] idx;
      logic [7:0] base;
      logic [7:0] step;
      int         gapmax;
      bit         exact;
   } vec_t;

   exp_t       exp_q[$];
   logic [7:0] src_q[$];
   vec_t       vecs[5];

   int n_assert = 0, n_fail = 0;
   int cyc = 0;
   int wr_cnt = 0, done_cnt = 0, dl_cnt = 0, rdy_cnt = 0;
   int viol_cnt = 0, extra_wr = 0;
   int last_wr_cyc = -1, done_cyc = 0, start_cyc = 0, done_base = 0;
   int gap_max = 0;
   bit exact = 1'b0;

   task automatic check(input string name, input int act, input int req);
      n_assert++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   always @(posedge clk_sys) cyc <= cyc + 1;

   // Byte source: presents queued bytes, inserting random idle gaps after each take.
   initial begin : source
      bit taken;
      int idle_left;
      idle_left = 0;
      src_valid = 1'b0;
      src_data  = 8'd0;
      forever begin
         @(negedge clk_sys);
         taken = src_valid && src_ready && !reset;
         @(posedge clk_sys);
         #1;
         if (taken) begin
            if (src_q.size() > 0) void'(src_q.pop_front());
            idle_left = $urandom_range(gap_max, 0);
         end
         if (idle_left > 0) begin
            idle_left--;
            src_valid = 1'b0;
         end else if (src_q.size() > 0) begin
            src_valid = 1'b1;
            src_data  = src_q[0];
         end else begin
            src_valid = 1'b0;
         end
      end
   end

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk_sys);
         if (!reset) begin
            if (src_ready) rdy_cnt++;
            if (src_ready && ioctl_wait) viol_cnt++;
            if (ioctl_download) dl_cnt++;
            if (done) begin
               done_cnt++;
               done_cyc = cyc;
            end
            if (ioctl_wr) begin
               wr_cnt++;
               if (exp_q.size() == 0) begin
                  extra_wr++;
               end else begin
                  e = exp_q.pop_front();
                  check("wr_addr", int'(ioctl_addr), int'(e.addr));
                  check("wr_dout", int'(ioctl_dout), int'(e.data));
               end
               if (last_wr_cyc >= 0) begin
                  if (exact) check("wr_spacing", cyc - last_wr_cyc, GAP + 2);
                  else       check("wr_spacing_min", int'((cyc - last_wr_cyc) >= GAP + 2), 1);
               end
               last_wr_cyc = cyc;
            end
         end
      end
   end

   task automatic kick(input int len, input logic [7:0] idx,
                       input logic [7:0] base, input logic [7:0] step);
      logic [7:0] b;
      for (int i = 0; i < len; i++) begin
         b = 8'(int'(base) + int'(step) * i);
         exp_q.push_back('{addr: 25'(i), data: b});
         src_q.push_back(b);
      end
      last_wr_cyc = -1;
      done_base   = done_cnt;
      @(posedge clk_sys);
      #1;
      start     = 1'b1;
      index     = idx;
      length    = 25'(len);
      start_cyc = cyc;
      @(posedge clk_sys);
      #1;
      start  = 1'b0;
      index  = 8'($urandom);
      length = 25'($urandom);
   endtask

   task automatic wait_done(input int budget);
      for (int i = 0; i < budget && done_cnt == done_base; i++) @(negedge clk_sys);
      check("done_seen", int'(done_cnt != done_base), 1);
      @(posedge clk_sys);
      #1;
      check("busy_after_done", int'(busy), 0);
      check("download_after_done", int'(ioctl_download), 0);
   endtask

   initial begin : main
      int w0, d0, dl0, r0;
      vecs[0] = '{len: 4,  idx: 8'h03, base: 8'h11, step: 8'h11, gapmax: 0, exact: 1'b1};
      vecs[1] = '{len: 0,  idx: 8'h05, base: 8'h00, step: 8'h00, gapmax: 0, exact: 1'b1};
      vecs[2] = '{len: 1,  idx: 8'hA0, base: 8'h5A, step: 8'h00, gapmax: 0, exact: 1'b1};
      vecs[3] = '{len: 12, idx: 8'h21, base: 8'hF0, step: 8'h07, gapmax: 6, exact: 1'b0};
      vecs[4] = '{len: 7,  idx: 8'h44, base: 8'h00, step: 8'h25, gapmax: 3, exact: 1'b0};

      reset = 1'b1; start = 1'b0; index = 8'd0; length = 25'd0; ioctl_wait = 1'b0;
      repeat (3) @(posedge clk_sys);
      #1;
      check("rst_download", int'(ioctl_download), 0);
      check("rst_wr", int'(ioctl_wr), 0);
      check("rst_addr", int'(ioctl_addr), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_src_ready", int'(src_ready), 0);
      reset = 1'b0;
      @(posedge clk_sys);
      #1;
      check("idle_index", int'(ioctl_index), 0);
      check("idle_done", int'(done), 0);

      for (int v = 0; v < 5; v++) begin
         exact   = vecs[v].exact;
         gap_max = vecs[v].gapmax;
         w0 = wr_cnt; d0 = done_cnt; dl0 = dl_cnt;
         kick(vecs[v].len, vecs[v].idx, vecs[v].base, vecs[v].step);
         wait_done(4000);
         check("vec_wr_count", wr_cnt - w0, vecs[v].len);
         check("vec_done_count", done_cnt - d0, 1);
         if (vecs[v].exact) begin
            check("vec_done_latency", done_cyc - start_cyc, PRE + POST + vecs[v].len * (GAP + 2));
            check("vec_download_cycles", dl_cnt - dl0, PRE + POST + vecs[v].len * (GAP + 2));
         end
         check("vec_index", int'(ioctl_index), int'(vecs[v].idx));
         check("vec_final_addr", int'(ioctl_addr), (vecs[v].len > 0) ? vecs[v].len - 1 : 0);
         check("vec_scoreboard_empty", exp_q.size(), 0);
      end

      // ioctl_wait held 50 cycles after the 2nd write.
      exact = 1'b0; gap_max = 0;
      w0 = wr_cnt;
      kick(5, 8'h77, 8'h81, 8'h13);
      for (int i = 0; i < 500 && wr_cnt < w0 + 2; i++) @(negedge clk_sys);
      check("wait_reached_2nd_wr", wr_cnt - w0, 2);
      @(posedge clk_sys);
      #1;
      ioctl_wait = 1'b1;
      d0 = wr_cnt; r0 = rdy_cnt;
      repeat (50) begin
         @(posedge clk_sys);
         #1;
      end
      check("wait_no_wr", wr_cnt - d0, 0);
      check("wait_no_ready", rdy_cnt - r0, 0);
      check("wait_download_held", int'(ioctl_download), 1);
      ioctl_wait = 1'b0;
      for (int i = 0; i < 100 && wr_cnt == d0; i++) @(negedge clk_sys);
      check("wait_3rd_wr_after_release", wr_cnt - d0, 1);
      wait_done(2000);
      check("wait_total_wr", wr_cnt - w0, 5);
      check("wait_final_addr", int'(ioctl_addr), 4);

      // start pulsed while busy must be ignored.
      w0 = wr_cnt;
      kick(3, 8'h12, 8'h40, 8'h01);
      repeat (5) @(posedge clk_sys);
      #1;
      start = 1'b1; index = 8'd7; length = 25'd9;
      @(posedge clk_sys);
      #1;
      start = 1'b0;
      check("busy_start_index", int'(ioctl_index), 8'h12);
      for (int i = 0; i < 500 && wr_cnt == w0; i++) @(negedge clk_sys);
      @(posedge clk_sys);
      #1;
      start = 1'b1; index = 8'd7; length = 25'd9;
      @(posedge clk_sys);
      #1;
      start = 1'b0;
      wait_done(2000);
      check("busy_start_wr_count", wr_cnt - w0, 3);
      check("busy_start_index_end", int'(ioctl_index), 8'h12);
      check("busy_start_addr_end", int'(ioctl_addr), 2);

      // Reset in GAP after the 3rd byte, then a fresh length-2 transfer.
      w0 = wr_cnt;
      kick(6, 8'h33, 8'h90, 8'h02);
      for (int i = 0; i < 500 && wr_cnt < w0 + 3; i++) @(negedge clk_sys);
      check("rst_mid_reached_3rd", wr_cnt - w0, 3);
      @(posedge clk_sys);
      #1;
      reset = 1'b1;
      #1;
      check("rst_mid_download", int'(ioctl_download), 0);
      check("rst_mid_wr", int'(ioctl_wr), 0);
      check("rst_mid_addr", int'(ioctl_addr), 0);
      check("rst_mid_dout", int'(ioctl_dout), 0);
      check("rst_mid_index", int'(ioctl_index), 0);
      check("rst_mid_busy", int'(busy), 0);
      exp_q.delete();
      src_q.delete();
      repeat (2) @(posedge clk_sys);
      #1;
      reset = 1'b0;
      w0 = wr_cnt; d0 = done_cnt;
      kick(2, 8'h66, 8'hC3, 8'h11);
      wait_done(2000);
      check("rst_restart_wr", wr_cnt - w0, 2);
      check("rst_restart_done", done_cnt - d0, 1);
      check("rst_restart_addr", int'(ioctl_addr), 1);
      check("rst_restart_index", int'(ioctl_index), 8'h66);

      check("ready_under_wait_cycles", viol_cnt, 0);
      check("unexpected_wr", extra_wr, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1);
   end

endmodule
